// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result stream bundle for the nibble-serial CLA sequencer.
// The master offers operands and accepts results; the slave is the sequencer.
interface cla_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-precision adder controller: streams one nibble per cycle through an
// external 4-bit CLA, LSB first, chaining the carry through a register.
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cla_nibble_sequencer_if.slave         bus,
    output logic [3:0]                    cla_a,
    output logic [3:0]                    cla_b,
    output logic                          cla_c_in,
    input  logic [3:0]                    cla_sum,
    input  logic                          cla_c_out
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     result_reg;
    logic [W-1:0]     result_next;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic             c_out_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] nib_base;

    assign nib_base = {idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid) next_state = ADD;
            ADD:  if (idx == LAST_IDX) next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        cla_a         = 4'h0;
        cla_b         = 4'h0;
        cla_c_in      = 1'b0;
        if (state == ADD) begin
            cla_a    = a_reg[nib_base +: 4];
            cla_b    = b_reg[nib_base +: 4];
            cla_c_in = carry_reg;
        end
    end

    always_comb begin
        result_next                = result_reg;
        result_next[nib_base +: 4] = cla_sum;
    end

    // The visible sum/c_out live in their own registers so they hold steady
    // while the next operation overwrites result_reg nibble by nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            c_out_reg  <= 1'b0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.c_in;
                        idx       <= '0;
                    end
                end
                ADD: begin
                    result_reg <= result_next;
                    carry_reg  <= cla_c_out;
                    if (idx == LAST_IDX) begin
                        sum_reg   <= result_next;
                        c_out_reg <= cla_c_out;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum   = sum_reg;
    assign bus.c_out = c_out_reg;
endmodule
